relu_seq_ctrl: RTL

RELU_SEQ_CTRL -- requirements
Module: relu_seq_ctrl

---
 rtl/mnist_pkg.sv | 22 ++
 rtl/relu_seq_ctrl_if.sv | 41 ++++
 rtl/relu_unit.sv | 17 +
 rtl/relu_seq_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/mnist_pkg.sv
// Shared types and default sizing for the MNIST inference datapath blocks.
package mnist_pkg;

    localparam int unsigned NNeuronsDefault = 32;
    localparam int unsigned DataWDefault    = 32;

    // Smallest index width that can address n entries (at least one bit).
    function automatic int unsigned idx_w_for(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IdxWDefault = idx_w_for(NNeuronsDefault);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCapt,
        StOut,
        StDone
    } relu_state_e;

endpackage

// File: rtl/relu_seq_ctrl_if.sv
// Bus bundle for relu_seq_ctrl: FC1 result-memory read port plus the activation output stream.
interface relu_seq_ctrl_if #(
    parameter int unsigned DATA_W = mnist_pkg::DataWDefault,
    parameter int unsigned IDX_W  = mnist_pkg::IdxWDefault
) ();

    logic              rd_en;
    logic [IDX_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;

    // Controller side.
    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_idx,
        output out_last
    );

    // Memory and stream-consumer side.
    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_idx,
        input  out_last
    );

endinterface

// File: rtl/relu_unit.sv
// Combinational signed ReLU: strictly positive inputs pass, zero and negatives become zero.
module relu_unit
    import mnist_pkg::*;
#(
    parameter int unsigned DATA_W = DataWDefault
) (
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    logic w_positive;

    // Sign bit clear and not all-zero is exactly "signed value > 0".
    assign w_positive = ~i_data[DATA_W-1] & (|i_data);
    assign o_data     = w_positive ? i_data : '0;

endmodule

// File: rtl/relu_seq_ctrl.sv
// Walks the FC1 result memory, applies ReLU per element and streams activations out.
// Optional nonzero-activation counter port nz_count is built when RELU_SEQ_STATS_EN is defined.
module relu_seq_ctrl
    import mnist_pkg::*;
#(
    parameter int unsigned N_NEURONS = NNeuronsDefault,
    parameter int unsigned DATA_W    = DataWDefault,
    parameter int unsigned IDX_W     = idx_w_for(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 abort,
    relu_seq_ctrl_if.master      bus,
    output logic                 busy,
`ifdef RELU_SEQ_STATS_EN
    output logic                 done,
    output logic [IDX_W:0]       nz_count
`else
    output logic                 done
`endif
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_NEURONS - 1);

    relu_state_e       r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_rd_en;
    logic [IDX_W-1:0]  r_rd_addr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [IDX_W-1:0]  r_out_idx;
    logic              r_out_last;
    logic              r_busy;
    logic              r_done;

    logic [DATA_W-1:0] w_relu;
    logic              w_hs;

    relu_unit #(
        .DATA_W (DATA_W)
    ) u_relu (
        .i_data (bus.rd_data),
        .o_data (w_relu)
    );

    // out_valid is only ever set while in StOut, so this is the OUT handshake.
    assign w_hs = r_out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (abort) begin
            // Abort wins over start and over a same-cycle handshake.
            r_state     <= StIdle;
            r_rd_en     <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            r_done  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state   <= StRead;
                        r_idx     <= '0;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                StRead: begin
                    r_state <= StCapt;
                end
                StCapt: begin
                    r_out_data  <= w_relu;
                    r_out_idx   <= r_idx;
                    r_out_last  <= (r_idx == LastIdx);
                    r_out_valid <= 1'b1;
                    r_state     <= StOut;
                end
                StOut: begin
                    if (w_hs) begin
                        r_out_valid <= 1'b0;
                        if (r_out_last) begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= StRead;
                            r_idx     <= r_idx + 1'b1;
                            r_rd_addr <= r_idx + 1'b1;
                            r_rd_en   <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_en     = r_rd_en;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_last  = r_out_last;
    assign busy          = r_busy;
    assign done          = r_done;

`ifdef RELU_SEQ_STATS_EN
    logic [IDX_W:0] r_nz_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_nz_count <= '0;
        end else if (!abort) begin
            if (r_state == StIdle && start) begin
                r_nz_count <= '0;
            end else if (r_state == StOut && w_hs && (r_out_data != '0)) begin
                r_nz_count <= r_nz_count + 1'b1;
            end
        end
    end

    assign nz_count = r_nz_count;
`endif

endmodule
